// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 16-point radix-2 FFT datapath controller:
//   - default component width / fractional bits
//   - controller state enumeration
//   - W16^n twiddle table (n = 0..7) held at 2^16 scale, plus the rounding
//     helper that brings it down to any FRACTION <= 15
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_WORD_SIZE = 16;
    localparam int FFT_FRACTION  = 8;
    localparam int FFT_POINTS    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_t;

    // W16^n = cos(2*pi*n/16) - j*sin(2*pi*n/16), scaled by 2^16 and rounded.
    // Keeping the master copy at high precision lets one table serve any
    // FRACTION setting while still rounding to nearest at the target scale.
    localparam int TW_RE_Q16 [0:7] = '{
        65536, 60547, 46341, 25080, 0, -25080, -46341, -60547
    };
    localparam int TW_IM_Q16 [0:7] = '{
        0, -25080, -46341, -60547, -65536, -60547, -46341, -25080
    };

    // Round a 2^16-scaled value to 2^frac scale, half away from zero.
    // Operates on the magnitude so negative entries round symmetrically.
    function automatic int round_q16(input int v, input int frac);
        int half;
        int mag;
        int res;
        half = 32'sd1 <<< (15 - frac);
        if (v < 32'sd0) begin
            mag = -v;
        end else begin
            mag = v;
        end
        res = (mag + half) >>> (16 - frac);
        if (v < 32'sd0) begin
            res = -res;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/twiddle_rom16.sv
// ---------------------------------------------------------------------------
// twiddle_rom16
// Combinational twiddle lookup: n[2:0] -> W16^n as two's complement
// (re, im) components scaled by 2^FRACTION.
// Ports:
//   i_n   in  3          twiddle index n
//   o_re  out WORD_SIZE  real part
//   o_im  out WORD_SIZE  imaginary part
// ---------------------------------------------------------------------------
module twiddle_rom16
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = FFT_WORD_SIZE,
    parameter int FRACTION  = FFT_FRACTION
) (
    input  logic [2:0]           i_n,
    output logic [WORD_SIZE-1:0] o_re,
    output logic [WORD_SIZE-1:0] o_im
);

    // Table lookup; the rounding collapses to constants per entry.
    always_comb begin
        o_re = WORD_SIZE'(round_q16(TW_RE_Q16[i_n], FRACTION));
        o_im = WORD_SIZE'(round_q16(TW_IM_Q16[i_n], FRACTION));
    end

endmodule

// File: rtl/butterfly_feeder.sv
// ---------------------------------------------------------------------------
// butterfly_feeder
// Initiator side of the radix-2 butterfly handshake. Holds a 16-point
// complex sample buffer and, on command, runs one in-place radix-2 DIT
// stage: eight operand/twiddle sets are issued to an external butterfly,
// each result pair is written back to the buffer.
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_wr_en/addr/re/im           buffer write port (IDLE only)
//   i_rd_addr, o_rd_re/im        buffer read port, registered, 1 cycle
//   i_start, i_stage             start one stage s (IDLE only)
//   o_busy, o_stage_done         stage in progress / completion pulse
//   o_bf_start, o_bf_in*, o_bf_twiddle_*   operands to the butterfly
//   i_bf_done, i_bf_out*         results from the butterfly
// ---------------------------------------------------------------------------
module butterfly_feeder
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = FFT_WORD_SIZE,
    parameter int FRACTION  = FFT_FRACTION
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wr_en,
    input  logic [3:0]           i_wr_addr,
    input  logic [WORD_SIZE-1:0] i_wr_re,
    input  logic [WORD_SIZE-1:0] i_wr_im,
    input  logic [3:0]           i_rd_addr,
    output logic [WORD_SIZE-1:0] o_rd_re,
    output logic [WORD_SIZE-1:0] o_rd_im,
    input  logic                 i_start,
    input  logic [1:0]           i_stage,
    output logic                 o_busy,
    output logic                 o_stage_done,
    output logic                 o_bf_start,
    output logic [WORD_SIZE-1:0] o_bf_in0_re,
    output logic [WORD_SIZE-1:0] o_bf_in0_im,
    output logic [WORD_SIZE-1:0] o_bf_in1_re,
    output logic [WORD_SIZE-1:0] o_bf_in1_im,
    output logic [WORD_SIZE-1:0] o_bf_twiddle_re,
    output logic [WORD_SIZE-1:0] o_bf_twiddle_im,
    input  logic                 i_bf_done,
    input  logic [WORD_SIZE-1:0] i_bf_out0_re,
    input  logic [WORD_SIZE-1:0] i_bf_out0_im,
    input  logic [WORD_SIZE-1:0] i_bf_out1_re,
    input  logic [WORD_SIZE-1:0] i_bf_out1_im
);

    fsm_state_t r_state;
    fsm_state_t w_state_next;
    logic       w_start_ok;
    logic       w_wr_ok;

    logic [1:0] r_stage;
    logic [2:0] r_op;
    logic [3:0] r_idx0;
    logic [3:0] r_idx1;

    logic [3:0] w_h;
    logic [2:0] w_j;
    logic [3:0] w_idx0;
    logic [3:0] w_idx1;
    logic [2:0] w_n;
    logic [WORD_SIZE-1:0] w_tw_re;
    logic [WORD_SIZE-1:0] w_tw_im;

    logic [WORD_SIZE-1:0] r_buf_re [FFT_POINTS];
    logic [WORD_SIZE-1:0] r_buf_im [FFT_POINTS];

    logic [WORD_SIZE-1:0] r_res0_re;
    logic [WORD_SIZE-1:0] r_res0_im;
    logic [WORD_SIZE-1:0] r_res1_re;
    logic [WORD_SIZE-1:0] r_res1_im;

    logic [WORD_SIZE-1:0] r_rd_re;
    logic [WORD_SIZE-1:0] r_rd_im;
    logic                 r_busy;
    logic                 r_stage_done;
    logic                 r_bf_start;
    logic [WORD_SIZE-1:0] r_in0_re;
    logic [WORD_SIZE-1:0] r_in0_im;
    logic [WORD_SIZE-1:0] r_in1_re;
    logic [WORD_SIZE-1:0] r_in1_im;
    logic [WORD_SIZE-1:0] r_tw_re;
    logic [WORD_SIZE-1:0] r_tw_im;

    twiddle_rom16 #(
        .WORD_SIZE (WORD_SIZE),
        .FRACTION  (FRACTION)
    ) u_twiddle_rom (
        .i_n  (w_n),
        .o_re (w_tw_re),
        .o_im (w_tw_im)
    );

    // Pair mapping for op p of stage s: span h = 2^s, j = p mod h,
    // idx0 = (p div h) * 2h + j, idx1 = idx0 + h, twiddle n = j * 8/h.
    // For s = 3 the truncated h-1 wraps to 3'b111, i.e. mask all of p.
    always_comb begin
        w_h    = 4'd1 << r_stage;
        w_j    = r_op & (w_h[2:0] - 3'd1);
        w_idx0 = (({1'b0, r_op} >> r_stage) << ({1'b0, r_stage} + 3'd1)) | {1'b0, w_j};
        w_idx1 = w_idx0 + w_h;
        w_n    = w_j << (2'd3 - r_stage);
    end

    // Next-state decode; also qualifies which IDLE-only requests are taken.
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_wr_ok      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_ok = i_wr_en;
                if (i_start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_bf_done) begin
                    w_state_next = ST_WB;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WB: begin
                if (r_op == 3'd7) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sample buffer: host writes in IDLE, paired result writeback in WB.
    // A host write in the start cycle lands before ISSUE reads the buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < FFT_POINTS; k++) begin
                r_buf_re[k] <= '0;
                r_buf_im[k] <= '0;
            end
        end else if (w_wr_ok) begin
            r_buf_re[i_wr_addr] <= i_wr_re;
            r_buf_im[i_wr_addr] <= i_wr_im;
        end else if (r_state == ST_WB) begin
            r_buf_re[r_idx0] <= r_res0_re;
            r_buf_im[r_idx0] <= r_res0_im;
            r_buf_re[r_idx1] <= r_res1_re;
            r_buf_im[r_idx1] <= r_res1_im;
        end
    end

    // Registered read port.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_re <= '0;
            r_rd_im <= '0;
        end else begin
            r_rd_re <= r_buf_re[i_rd_addr];
            r_rd_im <= r_buf_im[i_rd_addr];
        end
    end

    // Stage sequencing: op counter, operand registers, result capture,
    // and the registered handshake/status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stage      <= 2'd0;
            r_op         <= 3'd0;
            r_idx0       <= 4'd0;
            r_idx1       <= 4'd0;
            r_res0_re    <= '0;
            r_res0_im    <= '0;
            r_res1_re    <= '0;
            r_res1_im    <= '0;
            r_busy       <= 1'b0;
            r_stage_done <= 1'b0;
            r_bf_start   <= 1'b0;
            r_in0_re     <= '0;
            r_in0_im     <= '0;
            r_in1_re     <= '0;
            r_in1_im     <= '0;
            r_tw_re      <= '0;
            r_tw_im      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_stage <= i_stage;
                        r_op    <= 3'd0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_idx0     <= w_idx0;
                    r_idx1     <= w_idx1;
                    r_in0_re   <= r_buf_re[w_idx0];
                    r_in0_im   <= r_buf_im[w_idx0];
                    r_in1_re   <= r_buf_re[w_idx1];
                    r_in1_im   <= r_buf_im[w_idx1];
                    r_tw_re    <= w_tw_re;
                    r_tw_im    <= w_tw_im;
                    r_bf_start <= 1'b1;
                end
                ST_WAIT: begin
                    if (i_bf_done) begin
                        r_res0_re  <= i_bf_out0_re;
                        r_res0_im  <= i_bf_out0_im;
                        r_res1_re  <= i_bf_out1_re;
                        r_res1_im  <= i_bf_out1_im;
                        r_bf_start <= 1'b0;
                    end
                end
                ST_WB: begin
                    if (r_op == 3'd7) begin
                        r_stage_done <= 1'b1;
                    end else begin
                        r_op <= r_op + 3'd1;
                    end
                end
                ST_DONE: begin
                    r_stage_done <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_bf_start   <= 1'b0;
                    r_stage_done <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_re         = r_rd_re;
    assign o_rd_im         = r_rd_im;
    assign o_busy          = r_busy;
    assign o_stage_done    = r_stage_done;
    assign o_bf_start      = r_bf_start;
    assign o_bf_in0_re     = r_in0_re;
    assign o_bf_in0_im     = r_in0_im;
    assign o_bf_in1_re     = r_in1_re;
    assign o_bf_in1_im     = r_in1_im;
    assign o_bf_twiddle_re = r_tw_re;
    assign o_bf_twiddle_im = r_tw_im;

endmodule

// File: tb/tb_butterfly_feeder.sv
// ---------------------------------------------------------------------------
// tb_butterfly_feeder
// Self-checking bench: behavioural butterfly with programmable latency,
// a stage-level reference model of the buffer, hand vectors and corner
// sequences (slow butterfly, busy rejection, reset mid-stage).
// ---------------------------------------------------------------------------
module tb_butterfly_feeder;

    localparam int FRAC  = 8;
    localparam int LIMIT = 3000;

    typedef struct packed {
        logic [15:0] a_re;
        logic [15:0] a_im;
        logic [15:0] b_re;
        logic [15:0] b_im;
        logic [15:0] w_re;
        logic [15:0] w_im;
    } op_t;

    typedef struct {
        logic [15:0] a_re, a_im, b_re, b_im;
        logic [15:0] o0_re, o0_im, o1_re, o1_im;
    } vec_t;

    logic        clk, rst;
    logic        wr_en;
    logic [3:0]  wr_addr, rd_addr;
    logic [15:0] wr_re, wr_im, rd_re, rd_im;
    logic        start;
    logic [1:0]  stage;
    logic        busy, stage_done, bf_start;
    logic [15:0] in0_re, in0_im, in1_re, in1_im, tw_re, tw_im;
    logic        bf_done, bf_done_m, spur_done;
    logic [15:0] out0_re, out0_im, out1_re, out1_im;

    assign bf_done = bf_done_m | spur_done;

    butterfly_feeder dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_re(wr_re), .i_wr_im(wr_im),
        .i_rd_addr(rd_addr), .o_rd_re(rd_re), .o_rd_im(rd_im),
        .i_start(start), .i_stage(stage), .o_busy(busy), .o_stage_done(stage_done),
        .o_bf_start(bf_start),
        .o_bf_in0_re(in0_re), .o_bf_in0_im(in0_im),
        .o_bf_in1_re(in1_re), .o_bf_in1_im(in1_im),
        .o_bf_twiddle_re(tw_re), .o_bf_twiddle_im(tw_im),
        .i_bf_done(bf_done),
        .i_bf_out0_re(out0_re), .i_bf_out0_im(out0_im),
        .i_bf_out1_re(out1_re), .i_bf_out1_im(out1_im)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] ref_re [16];
    logic [15:0] ref_im [16];
    op_t exp_q[$];
    op_t obs_q[$];
    bit  stable_err;
    int  bf_lat;
    int  bf_cnt;
    op_t bf_first;
    bit  inj_spur, inj_busy;
    bit  busy_mid;
    vec_t vecs [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else return -$rtoi(-x + 0.5);
    endfunction

    // W16^n from its definition, rounded to nearest at 2^FRAC scale.
    function automatic logic [31:0] tw_ref(input int n);
        real ang;
        ang = 2.0 * 3.14159265358979 * n / 16.0;
        return {16'(rnd($cos(ang) * 256.0)), 16'(rnd(-$sin(ang) * 256.0))};
    endfunction

    // Behavioural butterfly: out0 = a + b*w, out1 = a - b*w, product >>> FRAC.
    task automatic bf_calc(input op_t o, output logic [15:0] r0r, r0i, r1r, r1i);
        int ar, ai, br, bi, wr, wi, pr, pi;
        ar = $signed(o.a_re); ai = $signed(o.a_im);
        br = $signed(o.b_re); bi = $signed(o.b_im);
        wr = $signed(o.w_re); wi = $signed(o.w_im);
        pr = (br * wr - bi * wi) >>> FRAC;
        pi = (br * wi + bi * wr) >>> FRAC;
        r0r = 16'(ar + pr); r0i = 16'(ai + pi);
        r1r = 16'(ar - pr); r1i = 16'(ai - pi);
    endtask

    // Reference stage: butterflies between k and k+h within blocks of 2h,
    // twiddle W16^(j*8/h), blocks in ascending order.
    task automatic ref_stage(input int s);
        int h, a, b;
        op_t o;
        logic [31:0] w;
        logic [15:0] r0r, r0i, r1r, r1i;
        h = 1 << s;
        exp_q.delete();
        for (int blk = 0; blk < 16; blk += 2 * h) begin
            for (int j = 0; j < h; j++) begin
                a = blk + j;
                b = a + h;
                w = tw_ref(j * (8 / h));
                o = {ref_re[a], ref_im[a], ref_re[b], ref_im[b], w[31:16], w[15:0]};
                exp_q.push_back(o);
                bf_calc(o, r0r, r0i, r1r, r1i);
                ref_re[a] = r0r; ref_im[a] = r0i;
                ref_re[b] = r1r; ref_im[b] = r1i;
            end
        end
    endtask

    // Butterfly responder: counts cycles of o_bf_start, answers on cycle L.
    initial begin
        bf_done_m = 1'b0; bf_cnt = 0; stable_err = 1'b0;
        out0_re = '0; out0_im = '0; out1_re = '0; out1_im = '0;
        forever begin
            @(negedge clk);
            if (rst || !bf_start) begin
                bf_cnt = 0;
                bf_done_m = 1'b0;
            end else begin
                op_t cur;
                cur = {in0_re, in0_im, in1_re, in1_im, tw_re, tw_im};
                bf_cnt++;
                if (bf_cnt == 1) begin
                    bf_first = cur;
                    obs_q.push_back(cur);
                end else if (cur != bf_first) begin
                    stable_err = 1'b1;
                end
                if (bf_cnt == bf_lat) begin
                    bf_calc(cur, out0_re, out0_im, out1_re, out1_im);
                    bf_done_m = 1'b1;
                end else begin
                    bf_done_m = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_buf(input int a, input logic [15:0] re, input logic [15:0] im);
        wr_en = 1'b1; wr_addr = 4'(a); wr_re = re; wr_im = im;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_buf(input int a, output logic [15:0] re, output logic [15:0] im);
        rd_addr = 4'(a);
        tick();
        re = rd_re; im = rd_im;
    endtask

    task automatic load_ref();
        for (int a = 0; a < 16; a++) write_buf(a, ref_re[a], ref_im[a]);
    endtask

    task automatic random_ref();
        for (int a = 0; a < 16; a++) begin
            ref_re[a] = 16'($urandom);
            ref_im[a] = 16'($urandom);
        end
    endtask

    // Runs one stage; ncyc = cycles from the start cycle to o_stage_done.
    task automatic run_stage(input int s, input int lat, output int ncyc);
        bf_lat = lat; obs_q.delete(); stable_err = 1'b0; busy_mid = 1'b0;
        start = 1'b1; stage = 2'(s);
        tick();
        start = 1'b0;
        ncyc = 1;
        if (inj_spur) spur_done = 1'b1;
        while (!stage_done && ncyc < LIMIT) begin
            tick();
            ncyc++;
            spur_done = 1'b0;
            if (ncyc == 2) busy_mid = busy;
            if (inj_busy && ncyc == 10) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 4'd5;
                wr_re = 16'h7FFF; wr_im = 16'h7FFF;
            end
            if (inj_busy && ncyc == 13) begin
                start = 1'b0; wr_en = 1'b0;
            end
        end
        tick();
    endtask

    task automatic verify_stage(input string tag);
        logic [15:0] r, i;
        check({tag, "_opcount"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check($sformatf("%s_op%0d", tag, k), obs_q[k], exp_q[k]);
        check({tag, "_stable"}, stable_err, 0);
        check({tag, "_busy_mid"}, busy_mid, 1);
        check({tag, "_idle_after"}, {busy, stage_done, bf_start}, 0);
        for (int a = 0; a < 16; a++) begin
            read_buf(a, r, i);
            check($sformatf("%s_buf%0d", tag, a), {r, i}, {ref_re[a], ref_im[a]});
        end
    endtask

    initial begin
        int n, lat;
        logic [15:0] r, i;
        logic [31:0] acc;

        vecs[0] = '{16'h0200, 16'h0100, 16'h0300, 16'hFF00, 16'h0500, 16'h0000, 16'hFF00, 16'h0200};
        vecs[1] = '{16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0200, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{16'h7000, 16'h1000, 16'h1000, 16'hF000, 16'h8000, 16'h0000, 16'h6000, 16'h2000};
        vecs[3] = '{16'hFFFF, 16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFE, 16'h0002};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_re = '0; wr_im = '0;
        rd_addr = '0; start = 1'b0; stage = '0; spur_done = 1'b0;
        inj_spur = 1'b0; inj_busy = 1'b0; bf_lat = 1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_outputs", {rd_re, rd_im, busy, stage_done, bf_start, in0_re, in0_im,
                                in1_re, in1_im, tw_re, tw_im}, 0);

        // Write-to-read latency: write in cycle t appears from t+2.
        rd_addr = 4'd9;
        wr_en = 1'b1; wr_addr = 4'd9; wr_re = 16'h1234; wr_im = 16'h5678;
        tick();
        wr_en = 1'b0;
        check("rd_lat_t1_old", {rd_re, rd_im}, 32'h0);
        tick();
        check("rd_lat_t2_new", {rd_re, rd_im}, 32'h12345678);
        write_buf(9, 16'h0000, 16'h0000);

        // Stage 0 hand vectors on pair (0,1); remaining entries stay zero.
        for (int v = 0; v < 4; v++) begin
            write_buf(0, vecs[v].a_re, vecs[v].a_im);
            write_buf(1, vecs[v].b_re, vecs[v].b_im);
            run_stage(0, 3, n);
            check($sformatf("vec%0d_cycles", v), n, 41);
            check($sformatf("vec%0d_twiddle", v),
                  (obs_q.size() > 0) ? {obs_q[0].w_re, obs_q[0].w_im} : 32'hFFFFFFFF, 32'h01000000);
            read_buf(0, r, i);
            check($sformatf("vec%0d_buf0", v), {r, i}, {vecs[v].o0_re, vecs[v].o0_im});
            read_buf(1, r, i);
            check($sformatf("vec%0d_buf1", v), {r, i}, {vecs[v].o1_re, vecs[v].o1_im});
        end

        // Random data through all four stages, random butterfly latency.
        random_ref();
        load_ref();
        for (int s = 0; s < 4; s++) begin
            lat = $urandom_range(6, 1);
            run_stage(s, lat, n);
            check($sformatf("rand_s%0d_cycles", s), n, 8 * (lat + 2) + 1);
            if (s == 3 && obs_q.size() > 2)
                check("s3_n2_twiddle", {obs_q[2].w_re, obs_q[2].w_im}, 32'h00B5FF4B);
            ref_stage(s);
            verify_stage($sformatf("rand_s%0d", s));
        end

        // Slow butterfly with a spurious done during ISSUE of op 0.
        random_ref();
        load_ref();
        inj_spur = 1'b1;
        run_stage(1, 100, n);
        inj_spur = 1'b0;
        check("slow_cycles", n, 8 * 102 + 1);
        ref_stage(1);
        verify_stage("slow");

        // Start and write requests while busy must be ignored.
        random_ref();
        load_ref();
        inj_busy = 1'b1;
        run_stage(0, 3, n);
        inj_busy = 1'b0;
        check("busyrej_cycles", n, 41);
        tick(); tick();
        check("busyrej_no_restart", {busy, bf_start}, 0);
        ref_stage(0);
        verify_stage("busyrej");

        // Asynchronous reset while waiting on op 3.
        random_ref();
        load_ref();
        bf_lat = 10; obs_q.delete();
        start = 1'b1; stage = 2'd2;
        tick();
        start = 1'b0;
        n = 0;
        while (obs_q.size() < 4 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_reached_op3", obs_q.size(), 4);
        #2 rst = 1'b1;
        #1;
        check("rst_outputs_async", {rd_re, rd_im, busy, stage_done, bf_start, in0_re, in0_im,
                                    in1_re, in1_im, tw_re, tw_im}, 0);
        tick(); tick();
        rst = 1'b0;
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        check("rst_late_done_ignored", {busy, stage_done, bf_start}, 0);
        acc = '0;
        for (int a = 0; a < 16; a++) begin
            read_buf(a, r, i);
            acc = acc | {r, i};
        end
        check("rst_buf_cleared", acc, 0);
        random_ref();
        load_ref();
        run_stage(2, 2, n);
        check("post_rst_cycles", n, 8 * 4 + 1);
        ref_stage(2);
        verify_stage("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
